// File: rtl/input_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// input_conditioner
//   Synchronises, debounces and edge-detects the DE0 slide switches and the
//   branch_status push-button before they reach the picoMIPS core.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module input_conditioner #(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TICK_DIV       = 500000,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             btn_raw,
  input  logic             ack,
  output logic [WIDTH-1:0] sw_clean,
  output logic             sw_changed,
  output logic             branch_clean,
  output logic             branch_rise,
  output logic             branch_held
);

  localparam int c_NUM_IN = WIDTH + 1;
  localparam int c_CNT_W  = $clog2(TICK_DIV);

  logic [c_NUM_IN-1:0]                  w_in;
  logic [SYNC_STAGES-1:0][c_NUM_IN-1:0] r_sync;
  logic [c_NUM_IN-1:0]                  w_sync;
  logic [c_CNT_W-1:0]                   r_cnt;
  logic                                 w_tick;
  logic [c_NUM_IN-1:0]                  w_next_clean;
  logic [c_NUM_IN-1:0]                  r_clean;
  logic                                 r_sw_changed;
  logic                                 r_rise;
  logic                                 r_held;

  // Button rides along as the top bit so it shares the switch pipeline.
  assign w_in   = {btn_raw, sw_raw};
  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_tick = (r_cnt == c_CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < c_NUM_IN; i++) begin : g_bit
      logic [STABLE_SAMPLES-1:0] r_hist;
      logic [STABLE_SAMPLES-1:0] w_hist_nx;

      assign w_hist_nx = {r_hist[STABLE_SAMPLES-2:0], w_sync[i]};

      // Decision uses the window including the sample being shifted in now.
      always_comb begin
        w_next_clean[i] = r_clean[i];
        if (&w_hist_nx) begin
          w_next_clean[i] = 1'b1;
        end else if (~|w_hist_nx) begin
          w_next_clean[i] = 1'b0;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_hist <= '0;
        end else if (w_tick) begin
          r_hist <= w_hist_nx;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clean      <= '0;
      r_sw_changed <= 1'b0;
      r_rise       <= 1'b0;
      r_held       <= 1'b0;
    end else begin
      r_sw_changed <= w_tick && (w_next_clean[WIDTH-1:0] != r_clean[WIDTH-1:0]);
      r_rise       <= w_tick && w_next_clean[WIDTH] && !r_clean[WIDTH];
      if (w_tick) begin
        r_clean <= w_next_clean;
      end
      // A new press outranks a concurrent acknowledge.
      if (r_rise) begin
        r_held <= 1'b1;
      end else if (ack) begin
        r_held <= 1'b0;
      end
    end
  end

  assign sw_clean     = r_clean[WIDTH-1:0];
  assign branch_clean = r_clean[WIDTH];
  assign sw_changed   = r_sw_changed;
  assign branch_rise  = r_rise;
  assign branch_held  = r_held;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_input_conditioner
//   Directed self-checking bench, TICK_DIV=4, STABLE_SAMPLES=3, SYNC_STAGES=2.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module tb_input_conditioner;

  logic       clk;
  logic       reset;
  logic [7:0] sw_raw;
  logic       btn_raw;
  logic       ack;
  logic [7:0] sw_clean;
  logic       sw_changed;
  logic       branch_clean;
  logic       branch_rise;
  logic       branch_held;

  int n_chk;
  int n_err;

  input_conditioner #(
    .WIDTH(8),
    .SYNC_STAGES(2),
    .TICK_DIV(4),
    .STABLE_SAMPLES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_raw(sw_raw),
    .btn_raw(btn_raw),
    .ack(ack),
    .sw_clean(sw_clean),
    .sw_changed(sw_changed),
    .branch_clean(branch_clean),
    .branch_rise(branch_rise),
    .branch_held(branch_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int first;
    int pulses;
    int rises;
    int nonzero;
    int found;
    int last;
    int ticks;

    n_chk   = 0;
    n_err   = 0;
    reset   = 1'b1;
    sw_raw  = 8'hA5;
    btn_raw = 1'b1;
    ack     = 1'b0;

    // Outputs stay quiet while reset is held with live inputs.
    for (int i = 0; i < 4; i++) begin
      step();
      check("reset_hold", {19'd0, sw_clean, sw_changed, branch_clean, branch_rise, branch_held}, 32'd0);
    end

    // Release: A5 must appear on the third sample tick (edge 12).
    reset  = 1'b0;
    first  = -1;
    pulses = 0;
    rises  = 0;
    for (int e = 1; e <= 16; e++) begin
      step();
      if (sw_changed) pulses++;
      if (branch_rise) rises++;
      if (first < 0 && sw_clean == 8'hA5) first = e;
    end
    check("reset_release_latency", first, 12);
    check("reset_release_pulses", pulses, 1);
    check("reset_release_value", {24'd0, sw_clean}, 32'hA5);
    check("reset_release_btn", {31'd0, branch_clean}, 1);
    check("reset_release_rise", rises, 1);
    check("reset_release_held", {31'd0, branch_held}, 1);

    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_clears", {31'd0, branch_held}, 0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_while_clear", {31'd0, branch_held}, 0);

    // Release button and clear switches together.
    btn_raw = 1'b0;
    sw_raw  = 8'h00;
    rises   = 0;
    pulses  = 0;
    for (int e = 0; e < 16; e++) begin
      step();
      if (branch_rise) rises++;
      if (sw_changed) pulses++;
    end
    check("release_btn_level", {31'd0, branch_clean}, 0);
    check("release_no_rise", rises, 0);
    check("release_sw_level", {24'd0, sw_clean}, 0);
    check("release_sw_pulses", pulses, 1);

    // One tick window of glitch on bit 3 is sampled at most once.
    sw_raw = 8'h08;
    repeat (4) step();
    sw_raw  = 8'h00;
    pulses  = 0;
    nonzero = 0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (sw_changed) pulses++;
      if (sw_clean != 8'h00) nonzero++;
    end
    check("glitch_no_pulse", pulses, 0);
    check("glitch_no_change", nonzero, 0);

    // Bouncy press.
    rises = 0;
    btn_raw = 1'b1; step();
    btn_raw = 1'b0; step();
    btn_raw = 1'b1; step();
    btn_raw = 1'b0; step();
    btn_raw = 1'b1; step();
    for (int e = 0; e < 20; e++) begin
      step();
      if (branch_rise) rises++;
    end
    check("press_one_rise", rises, 1);
    check("press_level", {31'd0, branch_clean}, 1);
    check("press_held", {31'd0, branch_held}, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("press_ack", {31'd0, branch_held}, 0);

    // Ack coinciding with the held-set edge: set wins.
    btn_raw = 1'b0;
    repeat (16) step();
    btn_raw = 1'b1;
    found = 0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (branch_rise) begin
        found = 1;
        break;
      end
    end
    check("simul_rise_seen", found, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("simul_held_set", {31'd0, branch_held}, 1);
    check("simul_rise_single", {31'd0, branch_rise}, 0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("simul_then_ack", {31'd0, branch_held}, 0);

    // Prescaler period over 100 ticks.
    last  = -1;
    ticks = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (dut.w_tick) begin
        if (last >= 0) check("tick_period", i - last, 4);
        last = i;
        ticks++;
      end
    end
    check("tick_count", ticks, 100);

    // Reset in the middle of debouncing a new value discards history.
    sw_raw = 8'hFF;
    repeat (8) step();
    check("mid_before_reset", {24'd0, sw_clean}, 0);
    reset = 1'b1;
    step();
    check("mid_in_reset", {19'd0, sw_clean, sw_changed, branch_clean, branch_rise, branch_held}, 0);
    step();
    reset = 1'b0;
    first = -1;
    for (int e = 1; e <= 16; e++) begin
      step();
      if (first < 0 && sw_clean == 8'hFF) first = e;
    end
    check("mid_restart_latency", first, 12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Conditions raw board inputs (8 slide switches plus the branch_status push-button) before they reach the picoMIPS core.
- Runs on the 50 MHz board clock.
- Synchronises each input, debounces it using a shared sample tick with an N-sample stability filter, and produces clean levels.
- Also produces a one-cycle rising-edge pulse and a sticky press flag for branch_status.
- Sits between the DE0 pins and the core's SW and branch_status inputs.

Parameters:
- WIDTH, 8, number of switch inputs.
- SYNC_STAGES, 2, flip-flop synchroniser depth (legal range 2..4).
- TICK_DIV, 500000, clock cycles per debounce sample tick (10 ms at 50 MHz); minimum 2.
- STABLE_SAMPLES, 3, consecutive equal samples needed to accept a new level; minimum 2.

Ports:
- clk, input, 1, board clock (50 MHz fastclk).
- reset, input, 1, asynchronous active-high reset.
- sw_raw, input, WIDTH, raw switch pins.
- btn_raw, input, 1, raw branch_status button pin.
- ack, input, 1, clears branch_held (consumer acknowledge).
- sw_clean, output, WIDTH, debounced switch levels.
- sw_changed, output, 1, one-cycle pulse when any sw_clean bit updates.
- branch_clean, output, 1, debounced button level.
- branch_rise, output, 1, one-cycle pulse on a 0->1 transition of branch_clean.
- branch_held, output, 1, sticky press flag, set by branch_rise, cleared by ack.

Behaviour:
- Reset is asynchronous and active-high. It clears all synchroniser flops, the history registers, the prescaler and all outputs to 0. Assertion mid-debounce discards any partial history. After release, filtering starts from the all-zero state.
- Synchroniser: each of the WIDTH+1 inputs passes through SYNC_STAGES flops. The sync output is the last stage.
- Prescaler: a counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick is asserted for exactly one cycle when the count equals TICK_DIV-1.
  - The first tick after reset occurs at cycle TICK_DIV-1.
- History: on each tick, every input's sync value is shifted into its own STABLE_SAMPLES-deep history register. Between ticks, history holds.
- Accept rule: a clean bit updates in the cycle after a tick when both of these hold:
  - all STABLE_SAMPLES history bits, including the sample just shifted in, are equal;
  - that value differs from the current clean bit.
  Otherwise the clean bit holds. A glitch shorter than one tick period is ignored unless it is sampled; a single sampled glitch is rejected by the stability rule.
- Latency: from a stable input change to the clean update is SYNC_STAGES + (STABLE_SAMPLES-1)*TICK_DIV to SYNC_STAGES + STABLE_SAMPLES*TICK_DIV + 1 cycles.
- sw_changed: 1 in the same cycle any sw_clean bit changes value, else 0. Multiple bits changing on the same tick produce a single pulse.
- branch_rise: 1 in the same cycle branch_clean goes 0->1. No pulse on 1->0.
- branch_held:
  - set on branch_rise;
  - cleared on ack when branch_rise is not asserted in that cycle;
  - simultaneous branch_rise and ack leaves it set (set wins);
  - ack while already clear has no effect.
- Outputs are registered. There is no combinational path from any input to any output.

Test Plan:
- Reset hold: drive sw_raw=8'hA5 and btn_raw=1 during reset -> all outputs remain 0 throughout reset. With TICK_DIV=4, STABLE_SAMPLES=3, SYNC_STAGES=2, sw_clean=8'hA5 no later than cycle 2+3*4+1=15 after release, with one sw_changed pulse.
- Glitch rejection (TICK_DIV=4): hold sw_raw=0, then pulse bit 3 high for exactly one tick window -> sw_clean stays 8'h00 and sw_changed never asserts.
- Button press: btn_raw goes 0->1 with 5 cycles of bounce, then holds -> exactly one branch_rise pulse, branch_clean=1, and branch_held=1 until ack. Pulse ack for 1 cycle -> branch_held=0 on the next cycle.
- Simultaneous set/clear: assert ack in the same cycle as branch_rise -> branch_held=1 afterwards.
- Release and wrap: btn_raw 1->0, stable -> branch_clean falls with no branch_rise. Check the prescaler wrap over 100 ticks: tick period is exactly 4 cycles.
- Reset mid-debounce: change sw_raw to 8'hFF, assert reset after 2 ticks, then release -> filter restarts. sw_clean reaches 8'hFF only after a full 3 new stable samples.
